// File: rtl/input_state.sv
// Player-input stage of the colour-sequence game: debounces four buttons, encodes each
// accepted press to a colour and checks it against the sequence shown by display_state.
module input_state #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic        clk,
    input  logic        rst_input,
    input  logic        en_input,
    input  logic [31:0] seq_in_input,
    input  logic [3:0]  round_ctr,
    input  logic [3:0]  btn,
    output logic [1:0]  echo_colour,
    output logic        echo_oe,
    output logic        complete_input,
    output logic        fail_input
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int SW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PRESS,
        WAIT_RELEASE,
        DONE,
        FAIL
    } stateT;

    stateT           r_state;
    logic [3:0]      r_idx;
    logic [3:0]      r_target;
    logic [TW-1:0]   r_timeoutCnt;
    logic [SW-1:0]   r_stableCnt;
    logic [3:0]      r_prevBtn;
    logic [1:0]      r_echoColour;

    stateT           w_stateNext;
    logic [3:0]      w_idxNext;
    logic [3:0]      w_targetNext;
    logic [TW-1:0]   w_timeoutNext;
    logic [SW-1:0]   w_stableNext;
    logic [1:0]      w_echoNext;
    logic            w_oneHot;
    logic [1:0]      w_code;
    logic [1:0]      w_expected;

    assign w_oneHot   = (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);
    assign w_expected = seq_in_input[{r_idx, 1'b0} +: 2];

    always_comb begin
        w_code = 2'd0;
        case (btn)
            4'b0010: w_code = 2'd1;
            4'b0100: w_code = 2'd2;
            4'b1000: w_code = 2'd3;
            default: w_code = 2'd0;
        endcase
    end

    // State, index and counter registers; reset overrides everything else.
    always_ff @(posedge clk) begin
        if (rst_input) begin
            r_state      <= IDLE;
            r_idx        <= 4'd0;
            r_target     <= 4'd0;
            r_timeoutCnt <= '0;
            r_stableCnt  <= '0;
            r_prevBtn    <= 4'd0;
            r_echoColour <= 2'd0;
        end else begin
            r_state      <= w_stateNext;
            r_idx        <= w_idxNext;
            r_target     <= w_targetNext;
            r_timeoutCnt <= w_timeoutNext;
            r_stableCnt  <= w_stableNext;
            r_prevBtn    <= btn;
            r_echoColour <= w_echoNext;
        end
    end

    // Next-state logic; a press accepted on the timeout edge takes priority over the timeout.
    always_comb begin
        w_stateNext   = r_state;
        w_idxNext     = r_idx;
        w_targetNext  = r_target;
        w_timeoutNext = r_timeoutCnt;
        w_stableNext  = r_stableCnt;
        w_echoNext    = r_echoColour;

        case (r_state)
            IDLE: begin
                if (en_input) begin
                    w_stateNext   = WAIT_PRESS;
                    w_targetNext  = round_ctr;
                    w_idxNext     = 4'd0;
                    w_timeoutNext = '0;
                    w_stableNext  = '0;
                end
            end

            WAIT_PRESS: begin
                w_timeoutNext = r_timeoutCnt + TW'(1);
                if (!w_oneHot) begin
                    w_stableNext = '0;
                end else if (btn == r_prevBtn) begin
                    w_stableNext = r_stableCnt + SW'(1);
                end else begin
                    w_stableNext = SW'(1);
                end

                if (w_oneHot && (w_stableNext == SW'(DEBOUNCE_CYCLES))) begin
                    w_echoNext = w_code;
                    if (w_code == w_expected) begin
                        w_stateNext  = WAIT_RELEASE;
                        w_stableNext = '0;
                    end else begin
                        w_stateNext = FAIL;
                    end
                end else if (r_timeoutCnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_stateNext = FAIL;
                end
            end

            WAIT_RELEASE: begin
                if (btn == 4'd0) begin
                    w_stableNext = r_stableCnt + SW'(1);
                    if (w_stableNext == SW'(DEBOUNCE_CYCLES)) begin
                        if (r_idx == r_target) begin
                            w_stateNext = DONE;
                        end else begin
                            w_stateNext   = WAIT_PRESS;
                            w_idxNext     = r_idx + 4'd1;
                            w_stableNext  = '0;
                            w_timeoutNext = '0;
                        end
                    end
                end else begin
                    w_stableNext = '0;
                end
            end

            DONE:    w_stateNext = IDLE;
            FAIL:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    assign echo_colour    = r_echoColour;
    assign echo_oe        = (r_state == WAIT_RELEASE);
    assign complete_input = (r_state == DONE);
    assign fail_input     = (r_state == FAIL);

endmodule

// File: tb/tb_input_state.sv
// Directed bench for input_state: reset, full rounds, mismatch, timeout and mid-round reset.
module tb_input_state;

    logic        clk;
    logic        rst_input;
    logic        en_input;
    logic [31:0] seq_in_input;
    logic [3:0]  round_ctr;
    logic [3:0]  btn;
    logic [1:0]  echo_colour;
    logic        echo_oe;
    logic        complete_input;
    logic        fail_input;

    int checks = 0;
    int errors = 0;
    int completeCount = 0;
    int failCount = 0;

    input_state #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk           (clk),
        .rst_input     (rst_input),
        .en_input      (en_input),
        .seq_in_input  (seq_in_input),
        .round_ctr     (round_ctr),
        .btn           (btn),
        .echo_colour   (echo_colour),
        .echo_oe       (echo_oe),
        .complete_input(complete_input),
        .fail_input    (fail_input)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters observed mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (complete_input === 1'b1) completeCount++;
        if (fail_input === 1'b1) failCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startRound(input logic [3:0] r);
        round_ctr = r;
        en_input  = 1'b1;
        tick();
        en_input  = 1'b0;
    endtask

    task automatic test_reset();
        int c0;
        int f0;
        logic sawEcho;
        rst_input = 1'b1;
        tick();
        rst_input = 1'b0;
        checks++;
        if ({echo_colour, echo_oe, complete_input, fail_input} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 00000",
                     {echo_colour, echo_oe, complete_input, fail_input});
        end
        c0 = completeCount;
        f0 = failCount;
        sawEcho = 1'b0;
        btn = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (echo_oe !== 1'b0) sawEcho = 1'b1;
        end
        btn = 4'b0000;
        repeat (6) tick();
        checks++;
        if (sawEcho !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle_press_echo: got %b expected 0", sawEcho);
        end
        checks++;
        if ((completeCount - c0) + (failCount - f0) !== 0) begin
            errors++;
            $display("[TB] FAIL reset_idle_press_pulses: got %0d expected 0",
                     (completeCount - c0) + (failCount - f0));
        end
    endtask

    task automatic test_round0();
        int c0;
        int f0;
        c0 = completeCount;
        f0 = failCount;
        startRound(4'd0);
        btn = 4'b0001;
        repeat (3) tick();
        checks++;
        if (echo_oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL r0_early_echo_oe: got %b expected 0", echo_oe);
        end
        tick();
        checks++;
        if (echo_oe !== 1'b1 || echo_colour !== 2'd0) begin
            errors++;
            $display("[TB] FAIL r0_accept: got oe=%b colour=%0d expected oe=1 colour=0",
                     echo_oe, echo_colour);
        end
        repeat (2) tick();
        btn = 4'b0000;
        repeat (3) tick();
        checks++;
        if (complete_input !== 1'b0) begin
            errors++;
            $display("[TB] FAIL r0_early_complete: got %b expected 0", complete_input);
        end
        tick();
        checks++;
        if (complete_input !== 1'b1) begin
            errors++;
            $display("[TB] FAIL r0_complete: got %b expected 1", complete_input);
        end
        tick();
        checks++;
        if (completeCount - c0 !== 1 || failCount - f0 !== 0) begin
            errors++;
            $display("[TB] FAIL r0_pulse_counts: got complete=%0d fail=%0d expected 1/0",
                     completeCount - c0, failCount - f0);
        end
    endtask

    task automatic test_round3();
        int c0;
        int f0;
        c0 = completeCount;
        f0 = failCount;
        startRound(4'd3);
        for (int c = 0; c < 4; c++) begin
            btn = 4'b0001 << c;
            for (int t = 1; t <= 5; t++) begin
                if (c == 2 && t == 2) en_input = 1'b1;
                tick();
                en_input = 1'b0;
                if (t == 4) begin
                    checks++;
                    if (echo_oe !== 1'b1 || echo_colour !== 2'(c)) begin
                        errors++;
                        $display("[TB] FAIL r3_accept_%0d: got oe=%b colour=%0d expected oe=1 colour=%0d",
                                 c, echo_oe, echo_colour, c);
                    end
                end
            end
            btn = 4'b0000;
            for (int t = 1; t <= 5; t++) begin
                if (c == 1 && t == 5) en_input = 1'b1;
                tick();
                en_input = 1'b0;
                if (t == 4) begin
                    checks++;
                    if (complete_input !== (c == 3)) begin
                        errors++;
                        $display("[TB] FAIL r3_complete_after_%0d: got %b expected %b",
                                 c, complete_input, (c == 3));
                    end
                end
            end
        end
        checks++;
        if (completeCount - c0 !== 1 || failCount - f0 !== 0) begin
            errors++;
            $display("[TB] FAIL r3_pulse_counts: got complete=%0d fail=%0d expected 1/0",
                     completeCount - c0, failCount - f0);
        end
    endtask

    task automatic test_mismatch();
        int c0;
        int f0;
        logic sawEcho;
        c0 = completeCount;
        f0 = failCount;
        startRound(4'd1);
        btn = 4'b0001;
        repeat (5) tick();
        btn = 4'b0000;
        repeat (5) tick();
        btn = 4'b0100;
        repeat (3) tick();
        checks++;
        if (fail_input !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mm_early_fail: got %b expected 0", fail_input);
        end
        tick();
        checks++;
        if (fail_input !== 1'b1 || echo_oe !== 1'b0 || echo_colour !== 2'd2) begin
            errors++;
            $display("[TB] FAIL mm_fail: got fail=%b oe=%b colour=%0d expected fail=1 oe=0 colour=2",
                     fail_input, echo_oe, echo_colour);
        end
        tick();
        checks++;
        if (fail_input !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mm_fail_width: got %b expected 0", fail_input);
        end
        btn = 4'b0000;
        repeat (2) tick();
        sawEcho = 1'b0;
        btn = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (echo_oe !== 1'b0) sawEcho = 1'b1;
        end
        btn = 4'b0000;
        repeat (6) tick();
        checks++;
        if (sawEcho !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mm_back_to_idle: got echo=%b expected 0", sawEcho);
        end
        checks++;
        if (completeCount - c0 !== 0 || failCount - f0 !== 1) begin
            errors++;
            $display("[TB] FAIL mm_pulse_counts: got complete=%0d fail=%0d expected 0/1",
                     completeCount - c0, failCount - f0);
        end
    endtask

    task automatic test_timeout(input bit withGlitch);
        int f0;
        logic early;
        f0 = failCount;
        early = 1'b0;
        startRound(4'd0);
        for (int i = 1; i <= 99; i++) begin
            if (withGlitch && i >= 10 && i <= 12) btn = 4'b0010;
            else if (withGlitch && i >= 30 && i <= 49) btn = 4'b0011;
            else btn = 4'b0000;
            tick();
            if (fail_input !== 1'b0 || echo_oe !== 1'b0 || complete_input !== 1'b0) early = 1'b1;
        end
        btn = 4'b0000;
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_early_event_g%0d: got %b expected 0", withGlitch, early);
        end
        tick();
        checks++;
        if (fail_input !== 1'b1) begin
            errors++;
            $display("[TB] FAIL to_fail_g%0d: got %b expected 1", withGlitch, fail_input);
        end
        tick();
        checks++;
        if (fail_input !== 1'b0 || failCount - f0 !== 1) begin
            errors++;
            $display("[TB] FAIL to_single_pulse_g%0d: got fail=%b count=%0d expected 0/1",
                     withGlitch, fail_input, failCount - f0);
        end
    endtask

    task automatic test_reset_mid_round();
        int c0;
        int f0;
        startRound(4'd7);
        for (int c = 0; c < 2; c++) begin
            btn = 4'b0001 << c;
            repeat (5) tick();
            btn = 4'b0000;
            repeat (5) tick();
        end
        btn = 4'b0100;
        repeat (4) tick();
        checks++;
        if (echo_oe !== 1'b1 || echo_colour !== 2'd2) begin
            errors++;
            $display("[TB] FAIL mid_third_accept: got oe=%b colour=%0d expected oe=1 colour=2",
                     echo_oe, echo_colour);
        end
        c0 = completeCount;
        f0 = failCount;
        rst_input = 1'b1;
        tick();
        rst_input = 1'b0;
        btn = 4'b0000;
        checks++;
        if ({echo_colour, echo_oe, complete_input, fail_input} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got %b expected 00000",
                     {echo_colour, echo_oe, complete_input, fail_input});
        end
        repeat (8) tick();
        checks++;
        if (completeCount - c0 !== 0 || failCount - f0 !== 0) begin
            errors++;
            $display("[TB] FAIL mid_reset_pulses: got complete=%0d fail=%0d expected 0/0",
                     completeCount - c0, failCount - f0);
        end
        startRound(4'd0);
        btn = 4'b0001;
        repeat (5) tick();
        btn = 4'b0000;
        repeat (4) tick();
        checks++;
        if (complete_input !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_fresh_complete: got %b expected 1", complete_input);
        end
        tick();
        checks++;
        if (completeCount - c0 !== 1 || failCount - f0 !== 0) begin
            errors++;
            $display("[TB] FAIL mid_fresh_counts: got complete=%0d fail=%0d expected 1/0",
                     completeCount - c0, failCount - f0);
        end
    endtask

    initial begin
        rst_input    = 1'b1;
        en_input     = 1'b0;
        seq_in_input = 32'hE4E4E4E4;
        round_ctr    = 4'd0;
        btn          = 4'b0000;
        test_reset();
        test_round0();
        test_round3();
        test_mismatch();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid_round();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
